// File: rtl/alu_iter_unit.sv
// alu_iter_unit: registered EX-stage ALU with single-cycle logic/arith ops
// and iterative SRL (1 bit/cycle) and MULTU (shift-add, 1 bit/cycle).
// busy/done let the pipeline controller stall around multi-cycle ops.
module alu_iter_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             ovf
);

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_MULTU = 3'b011;
    localparam logic [2:0] OP_SRL   = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b110;
    localparam logic [2:0] OP_SLT   = 3'b111;

    // One extra bit so the counter can hold WIDTH when WIDTH == 2**SHW.
    localparam int CW = SHW + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

    state_t               state;
    logic [WIDTH-1:0]     sreg;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;

    logic [SHW-1:0]       shamt;
    logic [WIDTH-1:0]     add_r;
    logic [WIDTH-1:0]     sub_r;
    logic                 add_ovf;
    logic                 sub_ovf;
    logic                 slt_r;
    logic [WIDTH-1:0]     sc_lo;
    logic                 sc_ovf;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]     sreg_next;

    // Single-cycle datapath: evaluated directly on the live operands at E0.
    always_comb begin
        shamt   = b[SHW-1:0];
        add_r   = a + b;
        sub_r   = a - b;
        add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]);
        sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);
        slt_r   = sub_r[WIDTH-1] ^ sub_ovf;
        sc_lo   = '0;
        sc_ovf  = 1'b0;
        case (op)
            OP_AND: sc_lo = a & b;
            OP_OR:  sc_lo = a | b;
            OP_ADD: begin
                sc_lo  = add_r;
                sc_ovf = add_ovf;
            end
            OP_SUB: begin
                sc_lo  = sub_r;
                sc_ovf = sub_ovf;
            end
            OP_SLT: sc_lo = {{(WIDTH-1){1'b0}}, slt_r};
            OP_SRL: sc_lo = a;  // only reaches the result for a zero shift
            default: sc_lo = '0;
        endcase
    end

    // Iterative step logic: add-then-shift multiply with carry kept, 1-bit shifter.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        acc_next  = {mul_sum, acc[WIDTH-1:1]};
        sreg_next = sreg >> 1;
    end

    // Control FSM and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            lo     <= '0;
            hi     <= '0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
            sreg   <= '0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op == OP_SRL && shamt != '0) begin
                            sreg  <= a;
                            cnt   <= {1'b0, shamt};
                            busy  <= 1'b1;
                            state <= SHIFT;
                        end else if (op == OP_MULTU) begin
                            mcand  <= a;
                            mplier <= b;
                            acc    <= '0;
                            cnt    <= CW'(WIDTH);
                            busy   <= 1'b1;
                            state  <= MUL;
                        end else begin
                            lo   <= sc_lo;
                            hi   <= '0;
                            zero <= (sc_lo == '0);
                            ovf  <= sc_ovf;
                            done <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    sreg <= sreg_next;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        lo    <= sreg_next;
                        hi    <= '0;
                        zero  <= (sreg_next == '0);
                        ovf   <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        lo    <= acc_next[WIDTH-1:0];
                        hi    <= acc_next[2*WIDTH-1:WIDTH];
                        zero  <= (acc_next == '0);
                        ovf   <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iter_unit.sv
// Self-checking bench for alu_iter_unit (WIDTH=32): directed vector table,
// hand-written multi-cycle sequences, and random ops against a plain-arithmetic model.
module tb_alu_iter_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  lo;
    logic [W-1:0]  hi;
    logic          zero;
    logic          ovf;

    int checks   = 0;
    int failures = 0;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        zero;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vt[14];

    alu_iter_unit #(.WIDTH(32), .SHW(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .lo    (lo),
        .hi    (hi),
        .zero  (zero),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: results from signed/unsigned arithmetic, latency in cycles after E0.
    function automatic void model(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb,
                                  output logic [31:0] elo, output logic [31:0] ehi,
                                  output logic ez, output logic eo, output int elat);
        longint s;
        logic [63:0] p;
        int n;
        elo = '0; ehi = '0; eo = 1'b0; elat = 0;
        case (o)
            3'b000: elo = xa & xb;
            3'b001: elo = xa | xb;
            3'b010: begin
                s = longint'($signed(xa)) + longint'($signed(xb));
                elo = s[31:0];
                eo = (s > SMAX) || (s < SMIN);
            end
            3'b110: begin
                s = longint'($signed(xa)) - longint'($signed(xb));
                elo = s[31:0];
                eo = (s > SMAX) || (s < SMIN);
            end
            3'b111: elo = {31'b0, ($signed(xa) < $signed(xb))};
            3'b100: begin
                n = int'(xb[4:0]);
                elo = (n >= 32) ? 32'h0 : (xa >> n);
                elat = n;
            end
            3'b011: begin
                p = {32'b0, xa} * {32'b0, xb};
                elo = p[31:0];
                ehi = p[63:32];
                elat = 32;
            end
            default: ;
        endcase
        ez = (elo == 0) && (ehi == 0);
    endfunction

    // Issue one op, then scramble the inputs; wait (bounded) for done.
    task automatic run_op(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb,
                          output int lat, output int bcnt, output logic hold_bad,
                          output logic rdone, output logic rbusy,
                          output logic [31:0] rlo, output logic [31:0] rhi,
                          output logic rz, output logic ro);
        logic [31:0] plo, phi;
        @(negedge clk);
        plo = lo; phi = hi;
        start = 1'b1; op = o; a = xa; b = xb;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        lat = 0; bcnt = 0; hold_bad = 1'b0;
        while (!done && lat < 300) begin
            if (busy) bcnt++;
            if (lo !== plo || hi !== phi) hold_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        rdone = done; rbusy = busy;
        rlo = lo; rhi = hi; rz = zero; ro = ovf;
    endtask

    task automatic exec_check(input string name, input logic [2:0] o, input logic [31:0] xa,
                              input logic [31:0] xb, input logic [31:0] elo, input logic [31:0] ehi,
                              input logic ez, input logic eo, input int elat);
        int lat, bcnt;
        logic hold_bad, rdone, rbusy, rz, ro;
        logic [31:0] rlo, rhi;
        run_op(o, xa, xb, lat, bcnt, hold_bad, rdone, rbusy, rlo, rhi, rz, ro);
        chk($sformatf("%s.done_seen", name), 64'(rdone), 64'(1));
        chk($sformatf("%s.latency", name), 64'(lat), 64'(elat));
        chk($sformatf("%s.lo", name), 64'(rlo), 64'(elo));
        chk($sformatf("%s.hi", name), 64'(rhi), 64'(ehi));
        chk($sformatf("%s.zero", name), 64'(rz), 64'(ez));
        chk($sformatf("%s.ovf", name), 64'(ro), 64'(eo));
        chk($sformatf("%s.busy_at_done", name), 64'(rbusy), 64'(0));
        chk($sformatf("%s.busy_cycles", name), 64'(bcnt), 64'(elat));
        chk($sformatf("%s.hold_during_op", name), 64'(hold_bad), 64'(0));
        @(posedge clk); #1;
        chk($sformatf("%s.done_single_pulse", name), 64'(done), 64'(0));
        chk($sformatf("%s.result_held", name), {hi, lo}, {rhi, rlo});
    endtask

    initial begin
        logic [31:0] elo, ehi, plo, phi;
        logic ez, eo;
        logic [2:0] ro_op;
        logic [31:0] ra, rb;
        logic [63:0] prod;
        int elat, ndone, lat;

        // op, a, b, lo, hi, zero, ovf, latency
        vt[0]  = '{3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1'b1, 0};
        vt[1]  = '{3'b110, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 1'b1, 1'b0, 0};
        vt[2]  = '{3'b111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b0, 0};
        vt[3]  = '{3'b111, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h0, 1'b1, 1'b0, 0};
        vt[4]  = '{3'b100, 32'h80000000, 32'h00000004, 32'h08000000, 32'h0, 1'b0, 1'b0, 4};
        vt[5]  = '{3'b100, 32'h12345678, 32'h00000000, 32'h12345678, 32'h0, 1'b0, 1'b0, 0};
        vt[6]  = '{3'b100, 32'h80000000, 32'h0000001F, 32'h00000001, 32'h0, 1'b0, 1'b0, 31};
        vt[7]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 32};
        vt[8]  = '{3'b011, 32'h00000000, 32'h00000007, 32'h00000000, 32'h0, 1'b1, 1'b0, 32};
        vt[9]  = '{3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 1'b0, 1'b0, 0};
        vt[10] = '{3'b001, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 32'h0, 1'b0, 1'b0, 0};
        vt[11] = '{3'b101, 32'h00000005, 32'h00000003, 32'h00000000, 32'h0, 1'b1, 1'b0, 0};
        vt[12] = '{3'b110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 0};
        vt[13] = '{3'b100, 32'h000000F0, 32'hFFFFFF03, 32'h0000001E, 32'h0, 1'b0, 1'b0, 3};

        // Reset, with a start request present to show reset wins.
        rst = 1'b1; start = 1'b1; op = 3'b010; a = 32'd1; b = 32'd1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy", 64'(busy), 64'(0));
        chk("reset.done", 64'(done), 64'(0));
        chk("reset.lo_hi", {hi, lo}, 64'(0));
        chk("reset.zero_ovf", {62'b0, zero, ovf}, 64'(0));
        @(negedge clk);
        rst = 1'b0; start = 1'b0;

        for (int i = 0; i < 14; i++)
            exec_check($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b,
                       vt[i].lo, vt[i].hi, vt[i].zero, vt[i].ovf, vt[i].lat);

        // Back-to-back: second start presented during the first op's done cycle.
        @(negedge clk);
        start = 1'b1; op = 3'b010; a = 32'd1; b = 32'd2;
        @(posedge clk); #1;
        chk("b2b.first_done", 64'(done), 64'(1));
        chk("b2b.first_lo", 64'(lo), 64'(3));
        op = 3'b110; a = 32'd10; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b.second_done", 64'(done), 64'(1));
        chk("b2b.second_lo", 64'(lo), 64'(7));
        @(posedge clk); #1;
        chk("b2b.done_low_after", 64'(done), 64'(0));

        // MULTU with an ignored ADD start mid-flight and operands changed.
        @(negedge clk);
        start = 1'b1; op = 3'b011; a = 32'h12345678; b = 32'h9ABCDEF0;
        prod = 64'(32'h12345678) * 64'(32'h9ABCDEF0);
        @(posedge clk); #1;
        start = 1'b0; a = '0; b = '0;
        ndone = 0; lat = -1; plo = '0; phi = '0;
        for (int i = 0; i < 45; i++) begin
            if (done) begin
                ndone++;
                if (lat < 0) lat = i;
                plo = lo; phi = hi;
            end
            if (i == 4) begin
                start = 1'b1; op = 3'b010; a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk("ignore.done_count", 64'(ndone), 64'(1));
        chk("ignore.latency", 64'(lat), 64'(32));
        chk("ignore.product", {phi, plo}, prod);
        chk("ignore.idle_after", 64'(busy), 64'(0));

        // Reset at cycle 10 of a MULTU aborts it.
        @(negedge clk);
        start = 1'b1; op = 3'b011; a = 32'hFFFFFFFF; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort.busy", 64'(busy), 64'(0));
        chk("abort.done", 64'(done), 64'(0));
        chk("abort.lo_hi", {hi, lo}, 64'(0));
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("abort.no_done", 64'(ndone), 64'(0));
        exec_check("abort.add_after", 3'b010, 32'd2, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 0);

        // Random ops against the reference model.
        for (int i = 0; i < 80; i++) begin
            ro_op = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 0) rb = ra;
            model(ro_op, ra, rb, elo, ehi, ez, eo, elat);
            exec_check($sformatf("rnd%0d_op%0d", i, ro_op), ro_op, ra, rb, elo, ehi, ez, eo, elat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_iter_unit.md
Name: alu_iter_unit

Overview:
- Parametrised, registered ALU unit for the pipelined MIPS-Lite CPU, generalising the bit-slice ALU to WIDTH bits.
- Single-cycle ops: AND, OR, ADD, SUB, SLT.
- Multi-cycle ops: SRL (one bit per cycle) and MULTU (shift-add, one bit per cycle), producing a double-width result on lo/hi.
- Sits in EX; the pipeline controller uses busy/done to stall.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- SHW, 5, shift-amount width; WIDTH <= 2**SHW.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- op  input  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 SRL, 011 MULTU; others illegal
- a  input  WIDTH  operand A (SRL source, multiplicand)
- b  input  WIDTH  operand B (multiplier); SRL shift amount = b[SHW-1:0]
- busy  output  1  high while a multi-cycle op is in progress
- done  output  1  one-cycle pulse: result valid
- lo  output  WIDTH  result / product low half
- hi  output  WIDTH  product high half (MULTU only, else 0)
- zero  output  1  lo==0 (and hi==0 for MULTU), registered with result
- ovf  output  1  signed overflow for ADD/SUB; 0 for all other ops

Behaviour:
- Reset: while rst=1 at a clock edge, FSM goes to IDLE; busy=0, done=0, lo=0, hi=0, zero=0, ovf=0. rst has priority over start.
- Reset during SRL/MULTU aborts the op. No done is produced for the aborted op.
- FSM states: IDLE, SHIFT, MUL.
- Operands are captured at the accept edge E0 (start=1, busy=0). Later changes to a, b or op have no effect on the op in flight.
- start with busy=1 is ignored: no queueing, no effect.
- Single-cycle ops, updated at E0:
  - lo, zero, ovf loaded; hi=0.
  - done=1 for the cycle after E0; FSM stays IDLE.
  - A new start may be accepted in that same done cycle (back-to-back).
- ADD/SUB: two's complement, lo = low WIDTH bits. ovf = operands have same sign (after B inversion for SUB) and result sign differs.
- SLT: lo = {0..0, (a<b) signed}. Computed as SUB sign XOR SUB overflow. ovf=0.
- SRL, N = b[SHW-1:0]:
  - N=0: behaves as a single-cycle op, lo=a.
  - N>=WIDTH: saturates, lo=0 after N cycles (no modulo).
  - N>0: E0 loads shift reg=a, count=N, busy=1, state SHIFT. Each following edge shifts right by 1 (zero fill) and decrements count.
  - At edge E_N: lo/zero are valid, busy=0, state IDLE, done=1 for the cycle after E_N.
- MULTU, unsigned:
  - E0 loads multiplicand, multiplier and a 2*WIDTH-bit accumulator=0; count=WIDTH; busy=1; state MUL.
  - Each edge E1..E_WIDTH processes one multiplier bit, LSB first, using add-then-shift. Carry out of the upper-half add is kept (WIDTH+1-bit adder).
  - After E_WIDTH: {hi,lo} = a*b exactly, zero valid, busy=0, done=1 for one cycle.
- lo/hi/zero/ovf hold their value until the next accepted start. During a multi-cycle op they are not updated until the final edge.
- Illegal op: treated as single-cycle; lo=0, hi=0, zero=1, ovf=0, done after E0.
- done is never high for two consecutive cycles from a single start.
- busy never rises on a single-cycle op.

Test Plan (WIDTH=32):
- ADD a=0x7FFFFFFF, b=1 -> done the cycle after E0; lo=0x80000000, ovf=1, zero=0, busy never high. SUB a=5, b=5 -> lo=0, zero=1, ovf=0.
- SLT a=0xFFFFFFFF (-1), b=1 -> lo=1. SLT a=1, b=0xFFFFFFFF -> lo=0. Back-to-back starts in consecutive cycles both complete with one done pulse each.
- SRL a=0x80000000, b=4 -> busy high for 4 cycles, done after E4, lo=0x08000000. b=0 -> lo=a after 1 cycle. b=31 -> lo=1 after 31 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done after E32; hi=0xFFFFFFFE, lo=0x00000001. MULTU a=0, b=7 -> hi=lo=0, zero=1.
- During MULTU, pulse start with op=ADD at cycle 5 and change a/b -> ignored; product unchanged; exactly one done.
- Assert rst at cycle 10 of MULTU -> next cycle busy=0, done=0, lo=hi=0. A new ADD 2+3 afterwards -> lo=5 after 1 cycle.
